// File: rtl/isa_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states,
// default reset/halt words and the sequential PC step.
package isa_fetch_pkg;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_INCR           = 32'd4;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: walks a byte PC through a word-addressed Harvard
// instruction memory, registering each fetched word until a halt word is seen.
module instr_fetch_unit
    import isa_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  r_instr_pc;
    logic         r_instr_valid;
    logic         r_halted;
    logic [31:0]  r_fetch_count;

    // Redirect targets are forced word-aligned, so the low bits never matter.
    logic w_unused_redirect_bits;
    assign w_unused_redirect_bits = ^redirect_pc[1:0];

    assign instr_address = {2'b00, r_pc[31:2]};
    assign instr         = r_instr;
    assign instr_pc      = r_instr_pc;
    assign instr_valid   = r_instr_valid;
    assign halted        = r_halted;
    assign fetch_count   = r_fetch_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= FETCH_RUN;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_count <= 32'h0;
        end else begin
            case (r_state)
                FETCH_RUN: begin
                    // Redirect wins over both stall and halt detection; it only
                    // flushes the output slot, the last delivered word stays visible.
                    if (redirect) begin
                        r_pc          <= {redirect_pc[31:2], 2'b00};
                        r_instr_valid <= 1'b0;
                    end else if (!stall) begin
                        if (instr_readdata == HALT_WORD) begin
                            r_state       <= FETCH_HALTED;
                            r_halted      <= 1'b1;
                            r_instr_valid <= 1'b0;
                        end else begin
                            r_instr       <= instr_readdata;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_pc          <= r_pc + PC_INCR;
                            r_fetch_count <= r_fetch_count + 32'd1;
                        end
                    end
                end
                FETCH_HALTED: begin
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF: instruction word that halts fetch.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 instr_address  output  32  word index into the 32-bit-wide instruction memory.
REQ-006 instr_readdata  input  32  word returned combinationally by the instruction memory for instr_address.
REQ-007 stall  input  1  hold the fetch unit; the downstream stage is not accepting.
REQ-008 redirect  input  1  branch/jump taken; replace the PC this cycle.
REQ-009 redirect_pc  input  32  byte-address target, valid when redirect=1.
REQ-010 instr  output  32  registered fetched instruction.
REQ-011 instr_pc  output  32  byte address of instr.
REQ-012 instr_valid  output  1  instr/instr_pc hold a live instruction.
REQ-013 halted  output  1  fetch stopped on HALT_WORD.
REQ-014 fetch_count  output  32  number of instructions delivered with instr_valid=1 since reset.

Function
REQ-015 Internal byte PC register pc; instr_address SHALL equal {2'b00, pc[31:2]}, combinational from pc only.
REQ-016 FSM states: RUN and HALTED; reset enters RUN.
REQ-017 RUN, redirect=0, stall=0, instr_readdata!=HALT_WORD: instr<=instr_readdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, fetch_count<=fetch_count+1.
REQ-018 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 -> 0); fetch_count SHALL also wrap.
REQ-019 Fetch latency: the word at pc appears on instr exactly one clock edge after pc is presented.
REQ-020 RUN, stall=1, redirect=0: pc, instr, instr_pc, instr_valid and fetch_count SHALL hold.
REQ-021 redirect=1 in RUN has priority over stall and halt detection: pc<={redirect_pc[31:2],2'b00}, instr_valid<=0 (flush); instr, instr_pc and fetch_count hold.
REQ-022 RUN, redirect=0, stall=0, instr_readdata==HALT_WORD: state<=HALTED, halted<=1, instr_valid<=0, pc holds; HALT_WORD is not delivered and not counted.
REQ-023 RUN, stall=1 with HALT_WORD on instr_readdata: no halt until stall deasserts.
REQ-024 HALTED: all registers hold; stall and redirect are ignored; only reset_n exits.
REQ-025 No output SHALL depend combinationally on stall, redirect or instr_readdata.

Reset
REQ-026 reset_n=0 SHALL asynchronously set pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0, state=RUN.
REQ-027 Reset asserted mid-operation (including HALTED, stalled or redirecting) SHALL abort without any partial update; the first fetch after release is at RESET_PC.
REQ-028 Release of reset_n SHALL take effect at the first rising clk edge at which it is sampled high.

Structure
REQ-029 Shared package isa_fetch_pkg SHALL hold the FSM state enum, default RESET_PC, default HALT_WORD and the PC increment constant 4.
REQ-030 Single module, no sub-module; it connects directly to the 32x32 Harvard instruction memory.

Verification
REQ-031 Memory word0=32'h8C22_0000, word1=HALT_WORD, reset release -> cycle 1: instr=8C220000, instr_pc=0, valid=1, fetch_count=1; cycle 2: halted=1, valid=0, instr_address=1, held for 10 cycles.
REQ-032 Sequential words 0..3 non-halt, stall=1 at cycle 2 for 3 cycles -> instr/instr_pc frozen at 4, instr_address frozen at 2, fetch_count frozen at 2; resumes at instr_pc=8.
REQ-033 redirect=1, redirect_pc=32'h0000_0013 together with stall=1 -> next cycle instr_address=4, instr_valid=0; next fetch instr_pc=32'h10.
REQ-034 RESET_PC=32'hFFFF_FFFC, non-halt words -> instr_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
REQ-035 reset_n pulsed low between edges while HALTED with fetch_count=7 -> outputs zero immediately, halted=0, fetch restarts at RESET_PC.
REQ-036 HALT_WORD on instr_readdata while stall=1, then redirect=1 with stall=1 -> no halt; pc takes redirect target.
